// File: rtl/i2s_dac_transmitter.sv
// I2S master transmitter: buffers mono samples in a small FIFO and sends each one
// as a Philips I2S frame with the same word on the left and right channels.
module i2s_dac_transmitter #(
  parameter int DATA_WIDTH      = 32,
  parameter int SLOT_BITS       = 32,
  parameter int BCLK_HALF_DIV   = 16,
  parameter int FIFO_ADDR_WIDTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sample_valid,
  input  logic signed [DATA_WIDTH-1:0] audio_in,
  input  logic                         enable,
  output logic                         i2s_bclk,
  output logic                         i2s_lrclk,
  output logic                         i2s_sdata,
  output logic [FIFO_ADDR_WIDTH:0]     fifo_level,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int DEPTH = 2 ** FIFO_ADDR_WIDTH;
  localparam int DIV_W = $clog2(BCLK_HALF_DIV);
  localparam int BIT_W = $clog2(2 * SLOT_BITS);
  localparam logic [DIV_W-1:0]         DIV_LAST = DIV_W'(BCLK_HALF_DIV - 1);
  localparam logic [BIT_W-1:0]         BIT_LAST = BIT_W'(2 * SLOT_BITS - 1);
  localparam logic [BIT_W-1:0]         BIT_MID  = BIT_W'(SLOT_BITS);
  localparam logic [FIFO_ADDR_WIDTH:0] LVL_FULL = (FIFO_ADDR_WIDTH + 1)'(DEPTH);

  logic [SLOT_BITS-1:0]       mem [DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr;
  logic [FIFO_ADDR_WIDTH-1:0] rd_ptr;
  logic [DIV_W-1:0]           div_cnt;
  logic [BIT_W-1:0]           bit_cnt;
  logic [SLOT_BITS-1:0]       shift_reg;
  logic [SLOT_BITS-1:0]       word_reg;

  logic                 div_wrap;
  logic                 bclk_fall;
  logic                 frame_start;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 do_pop;
  logic                 do_push;
  logic [SLOT_BITS-1:0] pop_word;
  logic [SLOT_BITS-1:0] in_slot;

  // sample_valid is a one-cycle push strobe with no back-pressure: a push that
  // finds the FIFO full (and no pop in the same cycle) is dropped and flagged
  // on overflow one cycle later.
  assign div_wrap    = enable && (div_cnt == DIV_LAST);
  assign bclk_fall   = div_wrap && i2s_bclk;
  assign frame_start = bclk_fall && (bit_cnt == '0);
  assign fifo_empty  = (fifo_level == '0);
  assign fifo_full   = (fifo_level == LVL_FULL);
  assign do_pop      = frame_start && !fifo_empty;
  assign do_push     = sample_valid && (!fifo_full || do_pop);
  assign pop_word    = do_pop ? mem[rd_ptr] : '0;
  assign in_slot     = audio_in[DATA_WIDTH-1 -: SLOT_BITS];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= in_slot;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      overflow  <= sample_valid && fifo_full && !do_pop;
      underflow <= frame_start && fifo_empty;
    end
  end

  // word_reg holds the frame's slot so the right channel can reload the shifter
  // at the lrclk edge and bit 0 of the next frame can carry its LSB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt   <= '0;
      bit_cnt   <= '0;
      i2s_bclk  <= 1'b0;
      i2s_lrclk <= 1'b0;
      i2s_sdata <= 1'b0;
      shift_reg <= '0;
      word_reg  <= '0;
    end else if (!enable) begin
      div_cnt   <= '0;
      bit_cnt   <= '0;
      i2s_bclk  <= 1'b0;
      i2s_lrclk <= 1'b0;
      i2s_sdata <= 1'b0;
      shift_reg <= '0;
      word_reg  <= '0;
    end else begin
      div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
      if (div_wrap) i2s_bclk <= !i2s_bclk;
      if (bclk_fall) begin
        bit_cnt   <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
        i2s_lrclk <= (bit_cnt >= BIT_MID);
        if (bit_cnt == '0) begin
          i2s_sdata <= word_reg[0];
          word_reg  <= pop_word;
          shift_reg <= pop_word;
        end else begin
          i2s_sdata <= shift_reg[SLOT_BITS-1];
          shift_reg <= (bit_cnt == BIT_MID) ? word_reg : shift_reg << 1;
        end
      end
    end
  end

endmodule
